io_port_ctrl: RTL

//  Memory-mapped I/O port controller of the pipelined computer, directly upstream of the seven-segment display stage.

---
 rtl/io_port_pkg.sv | 16 +
 rtl/io_debounce.sv | 56 +++++
 rtl/io_port_ctrl.sv | 78 +++++++
 3 files changed

// File: rtl/io_port_pkg.sv
// Shared address map, status bit positions and load-path helper for the I/O port controller.
package io_port_pkg;

  localparam logic [31:0] ADDR_IN0  = 32'h0000_0080;
  localparam logic [31:0] ADDR_IN1  = 32'h0000_0084;
  localparam logic [31:0] ADDR_OUT0 = 32'h0000_00C0;
  localparam logic [31:0] ADDR_STAT = 32'h0000_00C4;

  localparam int CHG0_BIT = 0;
  localparam int CHG1_BIT = 1;

  function automatic logic [31:0] zext4(input logic [3:0] v);
    return {28'h000_0000, v};
  endfunction

endpackage

// File: rtl/io_debounce.sv
// Two-flop synchroniser followed by a stability filter for one switch bank.
// changed is high in the cycle whose rising edge commits a new stable value.
module io_debounce #(
  parameter int W               = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] raw,
  output logic [W-1:0] stable,
  output logic         changed
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [W-1:0]     s1_r;
  logic [W-1:0]     s2_r;
  logic [W-1:0]     cand_r;
  logic [W-1:0]     stable_r;
  logic [CNT_W-1:0] cnt_r;
  logic             accept_s;

  // The commit condition depends only on registered state, so changed is glitch-free.
  assign accept_s = (s2_r == cand_r) && (cand_r != stable_r) && (cnt_r == CNT_LAST);
  assign stable   = stable_r;
  assign changed  = accept_s;

  // Synchroniser, candidate tracking and stability counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_r     <= '0;
      s2_r     <= '0;
      cand_r   <= '0;
      stable_r <= '0;
      cnt_r    <= '0;
    end else begin
      s1_r <= raw;
      s2_r <= s1_r;
      if (s2_r != cand_r) begin
        cand_r <= s2_r;
        cnt_r  <= '0;
      end else if (cand_r != stable_r) begin
        if (accept_s) begin
          stable_r <= cand_r;
          cnt_r    <= '0;
        end else begin
          cnt_r <= cnt_r + CNT_W'(1);
        end
      end else begin
        cnt_r <= '0;
      end
    end
  end

endmodule

// File: rtl/io_port_ctrl.sv
// Memory-mapped I/O port controller: debounced switch inputs, CPU output register,
// sticky change flags and the combinational load multiplexer.
module io_port_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  sw_in0,
  input  logic [3:0]  sw_in1,
  input  logic [31:0] mem_addr,
  input  logic [31:0] io_wdata,
  input  logic        io_we,
  input  logic        io_rd,
  output logic [31:0] io_rdata,
  output logic [3:0]  in_port0,
  output logic [3:0]  in_port1,
  output logic [31:0] out_port0
);

  import io_port_pkg::*;

  logic [31:0] out0_r;
  logic [1:0]  chg_r;
  logic        chg0_set_s;
  logic        chg1_set_s;
  logic        out_we_s;
  logic        stat_clr_s;
  logic [31:0] rdata_s;

  io_debounce #(.W(4), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db0 (
    .clock   (clock),
    .reset   (reset),
    .raw     (sw_in0),
    .stable  (in_port0),
    .changed (chg0_set_s)
  );

  io_debounce #(.W(4), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db1 (
    .clock   (clock),
    .reset   (reset),
    .raw     (sw_in1),
    .stable  (in_port1),
    .changed (chg1_set_s)
  );

  assign out_we_s   = io_we && (mem_addr == ADDR_OUT0);
  assign stat_clr_s = io_rd && (mem_addr == ADDR_STAT);

  // Output register and sticky flags; a same-edge set overrides the read-clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      out0_r <= 32'h0000_0000;
      chg_r  <= 2'b00;
    end else begin
      if (out_we_s) begin
        out0_r <= io_wdata;
      end
      chg_r[CHG0_BIT] <= chg0_set_s | (chg_r[CHG0_BIT] & ~stat_clr_s);
      chg_r[CHG1_BIT] <= chg1_set_s | (chg_r[CHG1_BIT] & ~stat_clr_s);
    end
  end

  // Load data is decoded in the same cycle; unmapped addresses read as zero.
  always_comb begin
    rdata_s = 32'h0000_0000;
    case (mem_addr)
      ADDR_IN0:  rdata_s = zext4(in_port0);
      ADDR_IN1:  rdata_s = zext4(in_port1);
      ADDR_OUT0: rdata_s = out0_r;
      ADDR_STAT: rdata_s = {30'h0000_0000, chg_r[CHG1_BIT], chg_r[CHG0_BIT]};
      default:   rdata_s = 32'h0000_0000;
    endcase
  end

  assign io_rdata  = rdata_s;
  assign out_port0 = out0_r;

endmodule
